// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply controller computing c^d mod n by driving
// an external modular multiplier through a level req / pulsed ack handshake.
module rsa_modexp_ctrl #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    input  logic [W-1:0] n,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] m,
    output logic         mm_req,
    output logic [W-1:0] mm_a,
    output logic [W-1:0] mm_b,
    output logic [W-1:0] mm_n,
    input  logic         mm_ack,
    input  logic [W-1:0] mm_p
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] TOP = IW'(W - 1);

    typedef enum logic [2:0] {IDLE, CHECK, SCAN, SQR, MUL, DONE} state_t;

    state_t        state;
    logic [W-1:0]  c_r;
    logic [W-1:0]  d_r;
    logic [W-1:0]  acc;
    logic [IW-1:0] idx;

    // mm_n doubles as the captured modulus; a request is outstanding while
    // mm_req is high, and the cycle after an ack is always request-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            c_r    <= '0;
            d_r    <= '0;
            acc    <= W'(1);
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            m      <= '0;
            mm_req <= 1'b0;
            mm_a   <= '0;
            mm_b   <= '0;
            mm_n   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        c_r   <= c;
                        d_r   <= d;
                        mm_n  <= n;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (mm_n < W'(2)) begin
                        m     <= '0;
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (d_r == '0) begin
                        m     <= W'(1);
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        acc   <= W'(1);
                        idx   <= TOP;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (d_r[idx]) state <= SQR;
                    else          idx   <= idx - IW'(1);
                end
                SQR: begin
                    if (!mm_req) begin
                        mm_req <= 1'b1;
                        mm_a   <= acc;
                        mm_b   <= acc;
                    end else if (mm_ack) begin
                        mm_req <= 1'b0;
                        acc    <= mm_p;
                        if (d_r[idx]) begin
                            state <= MUL;
                        end else if (idx == '0) begin
                            m     <= mm_p;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx <= idx - IW'(1);
                        end
                    end
                end
                MUL: begin
                    if (!mm_req) begin
                        mm_req <= 1'b1;
                        mm_a   <= acc;
                        mm_b   <= c_r;
                    end else if (mm_ack) begin
                        mm_req <= 1'b0;
                        acc    <= mm_p;
                        if (idx == '0) begin
                            m     <= mm_p;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx   <= idx - IW'(1);
                            state <= SQR;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Scoreboard bench for rsa_modexp_ctrl with a behavioural modular multiplier
// of configurable random latency.
module tb_rsa_modexp_ctrl;

    localparam int W = 14;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] c, d, n;
    logic         busy, done, err;
    logic [W-1:0] m;
    logic         mm_req;
    logic [W-1:0] mm_a, mm_b, mm_n;
    logic         mm_ack;
    logic [W-1:0] mm_p;

    logic         model_ack;
    logic         inj_ack;
    logic [W-1:0] model_p;
    logic [W-1:0] cur_n;
    logic [W-1:0] op_a, op_b, op_n;
    logic [W-1:0] enc;
    logic         pend;
    int           cnt;
    int           lat_max = 1;
    int           txn_count = 0;
    int           done_count = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    int           t0;

    typedef struct packed {
        logic [W-1:0] m;
        logic         err;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    assign mm_ack = model_ack | inj_ack;
    assign mm_p   = model_p;

    always #5 clk = ~clk;

    rsa_modexp_ctrl #(.W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .c      (c),
        .d      (d),
        .n      (n),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .m      (m),
        .mm_req (mm_req),
        .mm_a   (mm_a),
        .mm_b   (mm_b),
        .mm_n   (mm_n),
        .mm_ack (mm_ack),
        .mm_p   (mm_p)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Naive repeated multiplication, deliberately unlike square-and-multiply.
    function automatic logic [W-1:0] ref_modexp(input int unsigned b, input int unsigned e, input int unsigned md);
        longint unsigned r;
        r = 64'(1 % md);
        for (int i = 0; i < int'(e); i++) r = (r * 64'(b)) % 64'(md);
        return W'(r);
    endfunction

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] md);
        longint unsigned p;
        p = (64'(a) * 64'(b)) % 64'(md);
        return W'(p);
    endfunction

    // Called at a negedge; start is sampled by the following rising edge.
    task automatic apply_stimulus(input logic [W-1:0] ci, input logic [W-1:0] di, input logic [W-1:0] ni,
                                  input logic [W-1:0] em, input logic ee);
        c     = ci;
        d     = di;
        n     = ni;
        cur_n = ni;
        start = 1'b1;
        exp_q.push_back({em, ee});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 2000; k++) begin
            if (done) break;
            @(negedge clk);
        end
        check_output({name, " done before timeout"}, 32'(k < 2000), 1);
        @(negedge clk);
        check_output({name, " busy low after done"}, busy, 0);
    endtask

    task automatic check_fast(input string name, input int tstart);
        check_output({name, " done low cycle1"}, done, 0);
        check_output({name, " busy cycle1"}, busy, 1);
        @(negedge clk);
        check_output({name, " done high cycle2"}, done, 1);
        check_output({name, " busy during done"}, busy, 1);
        @(negedge clk);
        check_output({name, " done one cycle"}, done, 0);
        check_output({name, " busy back low"}, busy, 0);
        check_output({name, " no mm traffic"}, 32'(txn_count - tstart), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check_output({name, " busy"}, busy, 0);
        check_output({name, " done"}, done, 0);
        check_output({name, " err"}, err, 0);
        check_output({name, " m"}, m, 0);
        check_output({name, " mm_req"}, mm_req, 0);
        check_output({name, " mm_a"}, mm_a, 0);
        check_output({name, " mm_b"}, mm_b, 0);
        check_output({name, " mm_n"}, mm_n, 0);
    endtask

    // Multiplier model: answers each request after 1..lat_max cycles.
    initial begin
        model_ack = 1'b0;
        model_p   = '0;
        pend      = 1'b0;
        cnt       = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_ack = 1'b0;
                pend      = 1'b0;
            end else begin
                #1;
                if (!rst_n) begin
                    model_ack = 1'b0;
                    pend      = 1'b0;
                end else if (model_ack) begin
                    model_ack = 1'b0;
                    pend      = 1'b0;
                    check_output("mm_req dropped after ack", mm_req, 0);
                end else if (pend) begin
                    check_output("mm_req held", mm_req, 1);
                    check_output("mm_a stable", mm_a, op_a);
                    check_output("mm_b stable", mm_b, op_b);
                    cnt--;
                    if (cnt <= 0) begin
                        model_ack = 1'b1;
                        model_p   = mulmod(op_a, op_b, op_n);
                    end
                end else if (mm_req) begin
                    pend = 1'b1;
                    txn_count++;
                    op_a = mm_a;
                    op_b = mm_b;
                    op_n = mm_n;
                    check_output("mm_n is captured n", mm_n, cur_n);
                    cnt = int'($urandom_range(1, lat_max)) - 1;
                    if (cnt <= 0) begin
                        model_ack = 1'b1;
                        model_p   = mulmod(op_a, op_b, op_n);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done) begin
            done_count++;
            if (exp_q.size() == 0) begin
                check_output("unexpected done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("result m", m, mon_e.m);
                check_output("err flag", err, mon_e.err);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        c       = '0;
        d       = '0;
        n       = '0;
        cur_n   = '0;
        inj_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Start on the first edge after release, 1-cycle multiplier.
        rst_n   = 1'b1;
        lat_max = 1;
        t0      = txn_count;
        apply_stimulus(14'd4, 14'd13, 14'd497, 14'd445, 1'b0);
        check_output("start accepted first edge", busy, 1);
        wait_done("4^13 mod 497");
        check_output("4^13 transactions", 32'(txn_count - t0), 7);

        t0 = txn_count;
        apply_stimulus(14'd4, 14'd0, 14'd497, 14'd1, 1'b0);
        check_fast("d=0", t0);

        t0 = txn_count;
        apply_stimulus(14'd4, 14'd13, 14'd1, 14'd0, 1'b1);
        check_fast("n=1", t0);

        // RSA round trip with random multiplier latency.
        lat_max = 5;
        enc = ref_modexp(65, 89, 10573);
        t0  = txn_count;
        apply_stimulus(14'd65, 14'd89, 14'd10573, enc, 1'b0);
        wait_done("encrypt");
        check_output("encrypt transactions", 32'(txn_count - t0), 11);
        t0 = txn_count;
        apply_stimulus(enc, 14'd233, 14'd10573, 14'd65, 1'b0);
        wait_done("decrypt");
        check_output("decrypt transactions", 32'(txn_count - t0), 13);

        // Base not reduced modulo n.
        apply_stimulus(14'd600, 14'd13, 14'd497, ref_modexp(600, 13, 497), 1'b0);
        wait_done("c>=n");

        // Start pulses while busy must not disturb the running operation.
        lat_max = 3;
        apply_stimulus(14'd4, 14'd13, 14'd497, 14'd445, 1'b0);
        for (int i = 0; i < 6; i++) begin
            c     = 14'd7;
            d     = 14'd5;
            n     = 14'd300;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            check_output("mm_n held while busy", mm_n, 497);
        end
        wait_done("start ignored while busy");

        // Reset while a multiplier request is outstanding.
        lat_max = 5;
        apply_stimulus(14'd4, 14'd13, 14'd497, 14'd445, 1'b0);
        begin
            int k;
            for (k = 0; k < 200; k++) begin
                if (mm_req) break;
                @(negedge clk);
            end
            check_output("mm_req seen before reset", 32'(k < 200), 1);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async reset");
        inj_ack = 1'b1;
        @(negedge clk);
        inj_ack = 1'b0;
        exp_q.delete();
        check_reset_outputs("ack during reset");
        rst_n   = 1'b1;
        inj_ack = 1'b1;
        @(negedge clk);
        inj_ack = 1'b0;
        check_reset_outputs("late ack after reset");

        apply_stimulus(14'd4, 14'd13, 14'd497, 14'd445, 1'b0);
        wait_done("clean run after reset");

        repeat (3) @(negedge clk);
        check_output("scoreboard drained", 32'(exp_q.size()), 0);
        check_output("done pulse count", 32'(done_count), 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rsa_modexp_ctrl.md
RSA_MODEXP_CTRL -- requirements
Module: rsa_modexp_ctrl

Interface
REQ-001 SHALL have parameter W, default 14, meaning bit width of modulus, base, exponent and result.
REQ-002 SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin one exponentiation; sampled only in IDLE.
REQ-005 SHALL have port c  input  W  base (ciphertext or message).
REQ-006 SHALL have port d  input  W  exponent (private or public key).
REQ-007 SHALL have port n  input  W  modulus.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port err  output  1  modulus invalid (n<2); valid alongside done.
REQ-011 SHALL have port m  output  W  result c^d mod n; held until next accepted start.
REQ-012 SHALL have port mm_req  output  1  request to the external modular multiplier.
REQ-013 SHALL have ports mm_a, mm_b, mm_n  output  W each  multiplier operands and modulus.
REQ-014 SHALL have port mm_ack  input  1  one-cycle multiplier completion pulse.
REQ-015 SHALL have port mm_p  input  W  multiplier result (mm_a*mm_b) mod mm_n, valid with mm_ack.

Function
REQ-016 SHALL implement FSM states IDLE, CHECK, SCAN, SQR, MUL, DONE; all outputs registered.
REQ-017 SHALL, in IDLE with start=1, capture c, d, n into internal registers, clear err, and move to CHECK.
REQ-018 SHALL ignore start in every state other than IDLE; captured operands remain unchanged.
REQ-019 SHALL, in CHECK: n<2 -> m=0, err=1, go to DONE; else d==0 -> m=1, go to DONE; else acc=1, bit index=W-1, go to SCAN.
REQ-020 SHALL, in SCAN, consume one bit per cycle from MSB downward, skipping zero bits with no multiplier traffic, and enter SQR at the highest set bit k.
REQ-021 SHALL, in SQR, issue acc*acc; on mm_ack, acc=mm_p; then go to MUL if d[i]=1, else step to the next bit.
REQ-022 SHALL, in MUL, issue acc*c; on mm_ack, acc=mm_p; then step to the next bit.
REQ-023 SHALL, on stepping: if i==0, m=acc and go to DONE; else i=i-1 and go to SQR.
REQ-024 SHALL issue exactly (k+1)+popcount(d) multiplier transactions per operation.
REQ-025 SHALL raise mm_req with mm_a, mm_b, mm_n stable and hold all until the cycle mm_ack is sampled, then drop mm_req the next cycle; no new request in that same cycle.
REQ-026 SHALL tolerate any multiplier latency of 1 or more cycles, and ignore mm_ack while mm_req=0.
REQ-027 SHALL drive mm_n from captured n throughout; c>=n SHALL be passed unreduced (the multiplier reduces).
REQ-028 SHALL assert done for exactly one cycle in DONE, then return to IDLE; busy stays high during DONE.
REQ-029 SHALL complete d==0 or n<2 in exactly 2 cycles after the start sample, with done high in the second.

Reset
REQ-030 SHALL, on rst_n low at any time including mid-transaction, force IDLE immediately: busy=0, done=0, err=0, mm_req=0, m=0, mm_a=mm_b=mm_n=0, acc=1.
REQ-031 SHALL, after rst_n release, accept start on the first rising edge.
REQ-032 SHALL allow a late mm_ack arriving after reset to have no effect.

Verification
REQ-033 SHALL cover c=4, d=13, n=497, multiplier model with 1-cycle ack -> m=445, err=0, exactly 7 mm_req transactions (4 SQR, 3 MUL), one done pulse.
REQ-034 SHALL cover round-trip n=10573, e=89, d=233 with random ack latency 1-5: encrypt 65, then decrypt the result -> m=65.
REQ-035 SHALL cover c=4, d=0, n=497 -> m=1, err=0, no mm_req, done 2 cycles after start; and n=1 -> m=0, err=1.
REQ-036 SHALL cover start pulsed repeatedly while busy with different c/d/n -> ignored; result matches the first operands.
REQ-037 SHALL cover rst_n low while mm_req=1, with mm_ack pulsed during and after reset -> all outputs at reset values immediately; the next clean run gives the correct m.
